// File: rtl/gpio_sw_serializer_if.sv
// rtl/gpio_sw_serializer_if.sv - switch input / GPIO header bundle for gpio_sw_serializer
// master: serializer side (reads SW, drives GPIO); slave: board/bench side.
interface gpio_sw_serializer_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] SW;
  logic [31:0]       GPIO;

  modport master (input SW, output GPIO);
  modport slave  (output SW, input GPIO);
endinterface

// File: rtl/gpio_sw_serializer.sv
// rtl/gpio_sw_serializer.sv - debounced SW to GPIO serial frame source (SCK/SDO/LAT/BUSY)
// Optional even-parity bit after the LSB when GPIO_PARITY_EN is defined.
module gpio_sw_serializer #(
  parameter int DATA_W     = 10,
  parameter int CLK_DIV    = 4,
  parameter int STABLE_CYC = 16
) (
  input logic                  CLOCK_50,
  input logic                  Resetn,
  gpio_sw_serializer_if.master bus
);

`ifdef GPIO_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif
  localparam int CNT_W = $clog2(STABLE_CYC);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(NB + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sw_meta_q, sw_meta_d;
  logic [DATA_W-1:0] sw_sync_q, sw_sync_d;
  logic [DATA_W-1:0] sw_prev_q, sw_prev_d;
  logic [DATA_W-1:0] last_sent_q, last_sent_d;
  logic [CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [NB-1:0]     shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sck_q, sck_d;
  logic              sdo_q, sdo_d;
  logic              lat_q, lat_d;
  logic              busy_q, busy_d;
  logic              stable;
  logic [NB-1:0]     frame_data;

`ifdef GPIO_PARITY_EN
  assign frame_data = {sw_sync_q, ^sw_sync_q};
`else
  assign frame_data = sw_sync_q;
`endif

  // A value that only just reached sw_sync must not ride on the old value's saturated count.
  assign stable = (stab_cnt_q == CNT_MAX) && (sw_sync_q == sw_prev_q);

  always_comb begin
    sw_meta_d   = bus.SW;
    sw_sync_d   = sw_meta_q;
    sw_prev_d   = sw_sync_q;
    stab_cnt_d  = stab_cnt_q;
    state_d     = state_q;
    last_sent_d = last_sent_q;
    shreg_d     = shreg_q;
    div_d       = div_q;
    bit_d       = bit_q;

    if (sw_sync_q != sw_prev_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != CNT_MAX) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (stable && (sw_sync_q != last_sent_q)) state_d = LOAD;
      end
      LOAD: begin
        shreg_d     = frame_data;
        last_sent_d = sw_sync_q;
        div_d       = '0;
        bit_d       = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q << 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered from next-state values so they line up with the state they describe.
    busy_d = (state_d != IDLE);
    sck_d  = (state_d == SHIFT) && (div_d >= DIV_HALF);
    sdo_d  = (state_d == SHIFT) && shreg_d[NB-1];
    lat_d  = (state_d == LATCH);
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_prev_q   <= '0;
      last_sent_q <= '0;
      stab_cnt_q  <= '0;
      shreg_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      sdo_q       <= 1'b0;
      lat_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      sw_prev_q   <= sw_prev_d;
      last_sent_q <= last_sent_d;
      stab_cnt_q  <= stab_cnt_d;
      shreg_q     <= shreg_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sck_q       <= sck_d;
      sdo_q       <= sdo_d;
      lat_q       <= lat_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.GPIO = {28'h0, busy_q, lat_q, sdo_q, sck_q};

endmodule

// File: tb/tb_gpio_sw_serializer.sv
// tb/tb_gpio_sw_serializer.sv - randomized self-checking bench for gpio_sw_serializer
// Frames are decoded from the GPIO pins and compared with values built from the applied SW.
module tb_gpio_sw_serializer;

  localparam int DATA_W     = 10;
  localparam int CLK_DIV    = 4;
  localparam int STABLE_CYC = 16;
`ifdef GPIO_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif
  localparam int FRAME_LEN = 1 + (NB + 2) * CLK_DIV;
  localparam int WAIT_MAX  = 400;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          busy_len;
    int          lat_len;
    int          idle_before;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gpio_sw_serializer_if #(.DATA_W(DATA_W)) sw_gpio ();

  gpio_sw_serializer #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .STABLE_CYC (STABLE_CYC)
  ) u_dut (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .bus      (sw_gpio.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] last_sent_m = '0;

  frame_t frames[$];
  frame_t cur;
  bit     in_frame = 0;
  bit     prev_sck = 0;
  int     idle_run = 0;
  int     busy_starts = 0;
  int     gpio_nonzero = 0;
  int     stray = 0;

  // Pin monitor: decodes one frame per BUSY pulse, sampling SDO on each SCK rise.
  always @(negedge clk) begin
    logic [31:0] g;
    if (!rst_n) begin
      in_frame = 0;
      prev_sck = 0;
      idle_run = 0;
    end else begin
      g = sw_gpio.GPIO;
      if (g != 32'h0) gpio_nonzero++;
      if ((g[31:4] != 28'h0) || (!g[3] && (g[2:0] != 3'b000))) stray++;
      if (g[3]) begin
        if (!in_frame) begin
          in_frame         = 1;
          cur.bits         = '0;
          cur.nbits        = 0;
          cur.busy_len     = 0;
          cur.lat_len      = 0;
          cur.idle_before  = idle_run;
          busy_starts++;
        end
        cur.busy_len++;
        if (g[2]) cur.lat_len++;
        if (g[0] && !prev_sck) begin
          cur.bits = {cur.bits[30:0], g[1]};
          cur.nbits++;
        end
        idle_run = 0;
      end else begin
        if (in_frame) begin
          frames.push_back(cur);
          in_frame = 0;
        end
        idle_run++;
      end
      prev_sck = g[0];
    end
  end

  // Expected shifted-in word: data MSB first, then an even-parity bit when enabled.
  function automatic logic [31:0] model_frame(input logic [DATA_W-1:0] v);
    logic [31:0] r;
    r = 32'(v);
`ifdef GPIO_PARITY_EN
    r = (r << 1) | 32'($countones(v) % 2);
`endif
    return r;
  endfunction

  task automatic wait_frame(output bit ok, output frame_t f);
    int n = 0;
    while (frames.size() == 0 && n < WAIT_MAX) begin
      @(posedge clk);
      n++;
    end
    ok = (frames.size() != 0);
    if (ok) f = frames.pop_front();
    else f = '{bits: '0, nbits: 0, busy_len: 0, lat_len: 0, idle_before: 0};
  endtask

  task automatic wait_bits(input int nb, output bit ok);
    int n = 0;
    while (!(in_frame && cur.nbits == nb) && n < WAIT_MAX) begin
      @(posedge clk);
      n++;
    end
    ok = in_frame && (cur.nbits == nb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_gpio.SW = '0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (sw_gpio.GPIO !== 32'h0) begin
      n_fail++; $display("FAIL reset_gpio: got %h expected %h", sw_gpio.GPIO, 32'h0);
    end
    rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    n_assert++;
    if (busy_starts !== 0) begin
      n_fail++; $display("FAIL idle_busy: got %0d busy pulses expected 0", busy_starts);
    end
    n_assert++;
    if (gpio_nonzero !== 0) begin
      n_fail++; $display("FAIL idle_gpio: got %0d nonzero cycles expected 0", gpio_nonzero);
    end
  endtask

  task automatic test_basic();
    bit ok;
    frame_t f;
    sw_gpio.SW = 10'h2A5;
    wait_frame(ok, f);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL basic_timeout: got no frame expected one");
    end else begin
      n_assert++;
      if (f.bits !== model_frame(10'h2A5) || f.nbits !== NB) begin
        n_fail++; $display("FAIL basic_bits: got %h/%0d expected %h/%0d", f.bits, f.nbits, model_frame(10'h2A5), NB);
      end
      n_assert++;
      if (f.busy_len !== FRAME_LEN) begin
        n_fail++; $display("FAIL basic_busy: got %0d expected %0d", f.busy_len, FRAME_LEN);
      end
      n_assert++;
      if (f.lat_len !== CLK_DIV) begin
        n_fail++; $display("FAIL basic_lat: got %0d expected %0d", f.lat_len, CLK_DIV);
      end
    end
    last_sent_m = 10'h2A5;
    repeat (100) @(posedge clk);
    n_assert++;
    if (frames.size() !== 0 || in_frame) begin
      n_fail++; $display("FAIL basic_single: got %0d extra frames expected 0", frames.size());
    end
  endtask

  task automatic test_glitch();
    int starts0;
    logic [DATA_W-1:0] pulses [3];
    starts0 = busy_starts;
    pulses[0] = 10'h000;
    pulses[1] = 10'h3FF;
    pulses[2] = 10'h000;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sw_gpio.SW = pulses[i];
      repeat (8) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      sw_gpio.SW = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      repeat ($urandom_range(1, 8)) @(posedge clk);
      #1;
    end
    sw_gpio.SW = last_sent_m;
    repeat (120) @(posedge clk);
    n_assert++;
    if (busy_starts !== starts0 || frames.size() !== 0) begin
      n_fail++; $display("FAIL glitch_no_frame: got %0d frames expected 0", busy_starts - starts0);
    end
  endtask

  task automatic test_random();
    bit ok;
    frame_t f;
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 6; i++) begin
      do v = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      while (v == last_sent_m || v == 10'h2A5);
      @(posedge clk); #1;
      sw_gpio.SW = v;
      wait_frame(ok, f);
      n_assert++;
      if (!ok) begin
        n_fail++; $display("FAIL random_timeout[%0d]: got no frame expected %h", i, v);
      end else begin
        n_assert++;
        if (f.bits !== model_frame(v) || f.nbits !== NB) begin
          n_fail++; $display("FAIL random_bits[%0d]: got %h/%0d expected %h/%0d", i, f.bits, f.nbits, model_frame(v), NB);
        end
        n_assert++;
        if (f.busy_len !== FRAME_LEN || f.lat_len !== CLK_DIV) begin
          n_fail++; $display("FAIL random_len[%0d]: got busy %0d lat %0d expected %0d %0d", i, f.busy_len, f.lat_len, FRAME_LEN, CLK_DIV);
        end
      end
      last_sent_m = v;
    end
  endtask

  task automatic test_change_mid_frame();
    bit ok;
    frame_t f;
    @(posedge clk); #1;
    sw_gpio.SW = 10'h2A5;
    wait_bits(3, ok);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL mid_third_rise: got no 3rd SCK rise expected one");
    end
    #1;
    sw_gpio.SW = 10'h155;
    wait_frame(ok, f);
    n_assert++;
    if (!ok || f.bits !== model_frame(10'h2A5) || f.nbits !== NB) begin
      n_fail++; $display("FAIL mid_first: got %h/%0d expected %h/%0d", f.bits, f.nbits, model_frame(10'h2A5), NB);
    end
    wait_frame(ok, f);
    n_assert++;
    if (!ok || f.bits !== model_frame(10'h155) || f.busy_len !== FRAME_LEN) begin
      n_fail++; $display("FAIL mid_second: got %h busy %0d expected %h busy %0d", f.bits, f.busy_len, model_frame(10'h155), FRAME_LEN);
    end
    n_assert++;
    if (f.idle_before !== 1) begin
      n_fail++; $display("FAIL mid_gap_idle: got %0d idle cycles expected 1", f.idle_before);
    end
    last_sent_m = 10'h155;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    frame_t f;
    @(posedge clk); #1;
    sw_gpio.SW = 10'h2A5;
    wait_bits(4, ok);
    repeat (2) @(posedge clk);
    #2;
    n_assert++;
    if (!ok || sw_gpio.GPIO[3] !== 1'b1) begin
      n_fail++; $display("FAIL rst_busy_before: got %b expected 1", sw_gpio.GPIO[3]);
    end
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (sw_gpio.GPIO !== 32'h0) begin
      n_fail++; $display("FAIL rst_async_gpio: got %h expected %h", sw_gpio.GPIO, 32'h0);
    end
    repeat (3) @(posedge clk);
    n_assert++;
    if (frames.size() !== 0) begin
      n_fail++; $display("FAIL rst_partial: got %0d frames expected 0", frames.size());
    end
    #1;
    rst_n = 1'b1;
    wait_frame(ok, f);
    n_assert++;
    if (!ok || f.bits !== model_frame(10'h2A5) || f.busy_len !== FRAME_LEN) begin
      n_fail++; $display("FAIL rst_resend: got %h busy %0d expected %h busy %0d", f.bits, f.busy_len, model_frame(10'h2A5), FRAME_LEN);
    end
    last_sent_m = 10'h2A5;
  endtask

  task automatic test_parity();
    bit ok;
    frame_t f;
    logic [DATA_W-1:0] vals [2];
    vals[0] = 10'h007;
    vals[1] = 10'h003;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      sw_gpio.SW = vals[i];
      wait_frame(ok, f);
      n_assert++;
      if (!ok || f.bits !== model_frame(vals[i]) || f.nbits !== NB || f.busy_len !== FRAME_LEN) begin
        n_fail++; $display("FAIL parity_frame[%0d]: got %h/%0d busy %0d expected %h/%0d busy %0d",
                           i, f.bits, f.nbits, f.busy_len, model_frame(vals[i]), NB, FRAME_LEN);
      end
`ifdef GPIO_PARITY_EN
      n_assert++;
      if (f.bits[0] !== (i == 0 ? 1'b1 : 1'b0) || f.busy_len !== 53) begin
        n_fail++; $display("FAIL parity_bit[%0d]: got %b busy %0d expected %b busy 53", i, f.bits[0], f.busy_len, (i == 0));
      end
`endif
      last_sent_m = vals[i];
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_random();
    test_change_mid_frame();
    test_reset_mid_frame();
    test_parity();
    n_assert++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL stray_pins: got %0d bad cycles expected 0", stray);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
